// File: rtl/alu_iter_pkg.sv
// Shared definitions for the iterative ALU: op codes, FSM state encoding, op-class helper.
// The divider is compiled in only when ALU_ITER_DIV_EN is defined.
package alu_iter_pkg;

  localparam int unsigned OPW = 4;

  localparam logic [OPW-1:0] OP_ADD   = 4'b0000;
  localparam logic [OPW-1:0] OP_SUB   = 4'b0001;
  localparam logic [OPW-1:0] OP_SLL   = 4'b0010;
  localparam logic [OPW-1:0] OP_OR    = 4'b0011;
  localparam logic [OPW-1:0] OP_AND   = 4'b0100;
  localparam logic [OPW-1:0] OP_SLTU  = 4'b0101;
  localparam logic [OPW-1:0] OP_SLT   = 4'b0110;
  localparam logic [OPW-1:0] OP_XOR   = 4'b0111;
  localparam logic [OPW-1:0] OP_MUL   = 4'b1000;
  localparam logic [OPW-1:0] OP_MULHU = 4'b1001;
  localparam logic [OPW-1:0] OP_DIVU  = 4'b1010;
  localparam logic [OPW-1:0] OP_REMU  = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } alu_state_t;

  // The eight legacy ops all sit in the lower half of the op-code space.
  function automatic logic is_single_cycle(input logic [OPW-1:0] op);
    return !op[OPW-1];
  endfunction

endpackage

// File: rtl/alu_iter_if.sv
// Operand/result handshake bundle between the control unit / writeback (master) and the ALU (slave).
interface alu_iter_if
  import alu_iter_pkg::*;
#(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [OPW-1:0]   ALUctr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             err;

  modport master (
    output in_valid, A, B, ALUctr, out_ready,
    input  in_ready, out_valid, out, zero, err
  );

  modport slave (
    input  in_valid, A, B, ALUctr, out_ready,
    output in_ready, out_valid, out, zero, err
  );
endinterface

// File: rtl/alu_iter_seq.sv
// Shared iteration datapath: radix-2 shift-add multiply and, with ALU_ITER_DIV_EN, restoring divide.
// The accumulator holds {hi, lo}; lo_c/hi_c expose the value after the current step.
module alu_iter_seq
  import alu_iter_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_mul,
`ifdef ALU_ITER_DIV_EN
  input  logic             start_div,
`endif
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo_c,
  output logic [WIDTH-1:0] hi_c,
  output logic             last_c
);
  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned AW  = 2 * WIDTH;

  logic [AW-1:0]    acc;
  logic [AW-1:0]    acc_nxt;
  logic [WIDTH-1:0] opnd;
  logic [SHW-1:0]   cnt;
  logic [WIDTH:0]   mul_sum;
  logic [AW-1:0]    mul_acc;
`ifdef ALU_ITER_DIV_EN
  logic             div_mode;
  logic [WIDTH:0]   rem_sh;
  logic             div_ge;
  logic [WIDTH-1:0] rem_new;
  logic [AW-1:0]    div_acc;
`endif

  // One iteration step; the remainder never exceeds WIDTH bits after a restoring subtract.
  always_comb begin
    mul_sum = {1'b0, acc[AW-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_acc = {mul_sum, acc[WIDTH-1:1]};
    acc_nxt = mul_acc;
`ifdef ALU_ITER_DIV_EN
    rem_sh  = acc[AW-1:WIDTH-1];
    div_ge  = (rem_sh >= {1'b0, opnd});
    rem_new = div_ge ? WIDTH'(rem_sh - {1'b0, opnd}) : rem_sh[WIDTH-1:0];
    div_acc = {rem_new, acc[WIDTH-2:0], div_ge};
    if (div_mode) acc_nxt = div_acc;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      opnd     <= '0;
      cnt      <= '0;
`ifdef ALU_ITER_DIV_EN
      div_mode <= 1'b0;
`endif
    end else if (start_mul) begin
      acc      <= {WIDTH'(0), b};
      opnd     <= a;
      cnt      <= '0;
`ifdef ALU_ITER_DIV_EN
      div_mode <= 1'b0;
    end else if (start_div) begin
      acc      <= {WIDTH'(0), a};
      opnd     <= b;
      cnt      <= '0;
      div_mode <= 1'b1;
`endif
    end else if (step) begin
      acc      <= acc_nxt;
      cnt      <= cnt + SHW'(1);
    end
  end

  assign lo_c   = acc_nxt[WIDTH-1:0];
  assign hi_c   = acc_nxt[AW-1:WIDTH];
  assign last_c = (cnt == SHW'(WIDTH - 1));

endmodule

// File: rtl/alu_iter.sv
// Multi-cycle ALU top: handshake FSM, single-cycle ops, and the shared multiply/divide iterator.
// Define ALU_ITER_DIV_EN to build DIVU/REMU; otherwise they report err like illegal ops.
module alu_iter
  import alu_iter_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic       clk,
  input logic       rst_n,
  alu_iter_if.slave bus
);
  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_MUL  = 2'(MUL);
`ifdef ALU_ITER_DIV_EN
  localparam logic [1:0] ST_DIV  = 2'(DIV);
`endif
  localparam logic [1:0] ST_DONE = 2'(DONE);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             hi_q;
  logic             hi_nxt;
  logic [WIDTH-1:0] out_nxt;
  logic             err_nxt;
  logic [WIDTH-1:0] single_c;
  logic             start_mul;
`ifdef ALU_ITER_DIV_EN
  logic             start_div;
`endif
  logic             step;
  logic [WIDTH-1:0] lo_c;
  logic [WIDTH-1:0] hi_c;
  logic             last_c;

  alu_iter_seq #(.WIDTH(WIDTH)) u_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_mul (start_mul),
`ifdef ALU_ITER_DIV_EN
    .start_div (start_div),
`endif
    .step      (step),
    .a         (bus.A),
    .b         (bus.B),
    .lo_c      (lo_c),
    .hi_c      (hi_c),
    .last_c    (last_c)
  );

  // Legacy single-cycle ops, evaluated straight off the presented operands.
  always_comb begin
    single_c = '0;
    case (bus.ALUctr)
      OP_ADD:  single_c = bus.A + bus.B;
      OP_SUB:  single_c = bus.A - bus.B;
      OP_SLL:  single_c = bus.B << bus.A[SHW-1:0];
      OP_OR:   single_c = bus.A | bus.B;
      OP_AND:  single_c = bus.A & bus.B;
      OP_SLTU: single_c = WIDTH'(bus.A < bus.B);
      OP_SLT:  single_c = WIDTH'($signed(bus.A) < $signed(bus.B));
      OP_XOR:  single_c = bus.A ^ bus.B;
      default: single_c = '0;
    endcase
  end

  // Next state and next output values; op[0] selects the high half for MULHU/REMU.
  always_comb begin
    state_nxt = state;
    hi_nxt    = hi_q;
    out_nxt   = bus.out;
    err_nxt   = bus.err;
    start_mul = 1'b0;
`ifdef ALU_ITER_DIV_EN
    start_div = 1'b0;
`endif
    step      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          hi_nxt = bus.ALUctr[0];
          if (is_single_cycle(bus.ALUctr)) begin
            out_nxt   = single_c;
            err_nxt   = 1'b0;
            state_nxt = ST_DONE;
          end else begin
            case (bus.ALUctr)
              OP_MUL, OP_MULHU: begin
                start_mul = 1'b1;
                state_nxt = ST_MUL;
              end
              OP_DIVU, OP_REMU: begin
`ifdef ALU_ITER_DIV_EN
                if (bus.B == '0) begin
                  out_nxt   = bus.ALUctr[0] ? bus.A : '1;
                  err_nxt   = 1'b0;
                  state_nxt = ST_DONE;
                end else begin
                  start_div = 1'b1;
                  state_nxt = ST_DIV;
                end
`else
                out_nxt   = '0;
                err_nxt   = 1'b1;
                state_nxt = ST_DONE;
`endif
              end
              default: begin
                out_nxt   = '0;
                err_nxt   = 1'b1;
                state_nxt = ST_DONE;
              end
            endcase
          end
        end
      end
      ST_MUL: begin
        step = 1'b1;
        if (last_c) begin
          out_nxt   = hi_q ? hi_c : lo_c;
          err_nxt   = 1'b0;
          state_nxt = ST_DONE;
        end
      end
`ifdef ALU_ITER_DIV_EN
      ST_DIV: begin
        step = 1'b1;
        if (last_c) begin
          out_nxt   = hi_q ? hi_c : lo_c;
          err_nxt   = 1'b0;
          state_nxt = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        if (bus.out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and registered handshake/result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      hi_q          <= 1'b0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out       <= '0;
      bus.zero      <= 1'b1;
      bus.err       <= 1'b0;
    end else begin
      state         <= state_nxt;
      hi_q          <= hi_nxt;
      bus.in_ready  <= (state_nxt == ST_IDLE);
      bus.out_valid <= (state_nxt == ST_DONE);
      bus.out       <= out_nxt;
      bus.zero      <= (out_nxt == '0);
      bus.err       <= err_nxt;
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Directed self-checking bench for alu_iter at WIDTH=32; expectations follow ALU_ITER_DIV_EN.
module tb_alu_iter;
  logic clk = 1'b0;
  logic rst_n;

  alu_iter_if #(.WIDTH(32)) bus ();

  alu_iter #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          total  = 0;
  int          passed = 0;
  logic [31:0] r_out;
  logic        r_zero;
  logic        r_err;
  int          r_cyc;
  logic        r_saw;
  int          vcount;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one op, wait (bounded) for out_valid, capture results; consume if out_ready is high.
  task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int max);
    int n;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    bus.in_valid = 1'b1;
    bus.ALUctr   = op;
    bus.A        = a;
    bus.B        = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    r_cyc = 0;
    r_saw = 1'b0;
    while (!bus.out_valid && r_cyc < max) begin
      if (bus.in_ready) r_saw = 1'b1;
      @(posedge clk); #1; r_cyc++;
    end
    r_out  = bus.out;
    r_zero = bus.zero;
    r_err  = bus.err;
    if (bus.out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.ALUctr    = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out", bus.out, 32'h0);
    chk("rst_zero", bus.zero, 1);
    chk("rst_err", bus.err, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_out_valid", bus.out_valid, 0);
    chk("idle_in_ready", bus.in_ready, 1);

    run(4'b0000, 32'd5, 32'd7, 50);
    chk("add_out", r_out, 32'd12);
    chk("add_lat", r_cyc, 0);
    chk("add_zero", r_zero, 0);
    chk("add_err", r_err, 0);
    chk("add_back_idle", bus.in_ready, 1);

    run(4'b0110, 32'hFFFFFFFF, 32'd1, 50);
    chk("slt_out", r_out, 32'd1);
    run(4'b0101, 32'hFFFFFFFF, 32'd1, 50);
    chk("sltu_out", r_out, 32'd0);
    chk("sltu_zero", r_zero, 1);
    run(4'b0010, 32'd33, 32'd1, 50);
    chk("sll_out", r_out, 32'd2);
    run(4'b0001, 32'd5, 32'd5, 50);
    chk("sub_out", r_out, 32'd0);
    chk("sub_zero", r_zero, 1);
    run(4'b0111, 32'hF0F0F0F0, 32'hFF00FF00, 50);
    chk("xor_out", r_out, 32'h0FF00FF0);
    run(4'b0011, 32'h000000F0, 32'h0000000F, 50);
    chk("or_out", r_out, 32'h000000FF);
    run(4'b0100, 32'h000000F0, 32'h0000003C, 50);
    chk("and_out", r_out, 32'h00000030);

    run(4'b1000, 32'hFFFFFFFF, 32'd2, 100);
    chk("mul_out", r_out, 32'hFFFFFFFE);
    chk("mul_lat", r_cyc, 32);
    chk("mul_busy", r_saw, 0);
    chk("mul_err", r_err, 0);
    run(4'b1001, 32'hFFFFFFFF, 32'd2, 100);
    chk("mulhu_out", r_out, 32'd1);
    chk("mulhu_lat", r_cyc, 32);
    run(4'b1000, 32'd12345, 32'd678, 100);
    chk("mul_small", r_out, 32'd8369910);

`ifdef ALU_ITER_DIV_EN
    run(4'b1010, 32'd100, 32'd7, 100);
    chk("divu_out", r_out, 32'd14);
    chk("divu_lat", r_cyc, 32);
    chk("divu_busy", r_saw, 0);
    run(4'b1011, 32'd100, 32'd7, 100);
    chk("remu_out", r_out, 32'd2);
    chk("remu_lat", r_cyc, 32);
    run(4'b1010, 32'd55, 32'd0, 100);
    chk("divz_out", r_out, 32'hFFFFFFFF);
    chk("divz_lat", r_cyc, 0);
    chk("divz_err", r_err, 0);
    run(4'b1011, 32'd9, 32'd0, 100);
    chk("remz_out", r_out, 32'd9);
    run(4'b1010, 32'hFFFFFFFF, 32'd1, 100);
    chk("divu_max", r_out, 32'hFFFFFFFF);
`else
    run(4'b1010, 32'd100, 32'd7, 100);
    chk("divu_off_out", r_out, 32'd0);
    chk("divu_off_err", r_err, 1);
    chk("divu_off_zero", r_zero, 1);
    chk("divu_off_lat", r_cyc, 0);
`endif

    // Back-pressure: result must hold while out_ready is low, new requests ignored.
    bus.out_ready = 1'b0;
    run(4'b0000, 32'd3, 32'd4, 50);
    chk("bp_out", r_out, 32'd7);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.ALUctr   = 4'b0001;
      bus.A        = 32'd1;
      bus.B        = 32'd2;
      @(posedge clk); #1;
      chk("bp_hold_out", bus.out, 32'd7);
      chk("bp_hold_valid", bus.out_valid, 1);
      chk("bp_hold_ready", bus.in_ready, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", bus.out_valid, 0);
    chk("bp_release_ready", bus.in_ready, 1);

    // Reset during a multiply: abort with no result pulse.
    bus.in_valid = 1'b1;
    bus.ALUctr   = 4'b1000;
    bus.A        = 32'd3;
    bus.B        = 32'd5;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midmul_ready", bus.in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", bus.in_ready, 1);
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_out", bus.out, 32'd0);
    chk("midrst_zero", bus.zero, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) vcount++;
    end
    chk("midrst_no_pulse", vcount, 0);
    chk("midrst_idle", bus.in_ready, 1);

    run(4'b1110, 32'd1, 32'd2, 50);
    chk("ill_out", r_out, 32'd0);
    chk("ill_zero", r_zero, 1);
    chk("ill_err", r_err, 1);
    chk("ill_lat", r_cyc, 0);
    run(4'b0000, 32'd1, 32'd1, 50);
    chk("post_ill_out", r_out, 32'd2);
    chk("post_ill_err", r_err, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_iter.md
# alu_iter

Parametrised, multi-cycle successor to the single-cycle CPU's combinational ALU. Executes the existing eight single-cycle operations plus iterative multiply and unsigned divide/remainder on a WIDTH-bit datapath. Operand/result exchange uses a valid/ready handshake, so the datapath can stall on long operations. Targets the next multi-cycle core, where the control unit drives `in_*` and writeback consumes `out_*`.

## Interface
- `WIDTH`, 32, operand/result width in bits; must be ≥ 4 and a power of two.
- `SHW`, `$clog2(WIDTH)`, shift-amount width; derived, not overridden.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_valid`  in  1  operands and op presented.
- `in_ready`  out  1  block can accept an op.
- `A`, `B`  in  WIDTH  operands.
- `ALUctr`  in  4  operation code.
- `out_valid`  out  1  result held valid.
- `out_ready`  in  1  consumer takes the result.
- `out`  out  WIDTH  result.
- `zero`  out  1  high when `out` == 0.
- `err`  out  1  illegal op, or DIV/REM op with the divider compiled out.

## Operation
- Op codes:
  - 0000 ADD A+B; 0001 SUB A−B; 0010 SLL B<<A[SHW-1:0]; 0011 OR; 0100 AND.
  - 0101 SLTU (A<B unsigned, result 0/1); 0110 SLT (signed); 0111 XOR.
  - 1000 MUL (low WIDTH bits of A×B); 1001 MULHU (high WIDTH bits, unsigned).
  - 1010 DIVU A/B; 1011 REMU A%B.
  - 1100–1111: illegal, `out`=0, `err`=1.
- All arithmetic is modulo 2^WIDTH; carries and overflow are discarded.
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`, latch A, B, ALUctr. Single-cycle or illegal op → DONE; MUL/MULHU → MUL; DIVU/REMU with B≠0 → DIV; DIVU/REMU with B=0 → DONE.
  - MUL: radix-2 shift-add on a 2·WIDTH accumulator; iteration counter runs 0..WIDTH-1, then → DONE.
  - DIV: restoring division, one quotient bit per cycle, WIDTH cycles, then → DONE.
  - DONE: `out_valid`=1; `out`, `zero`, `err` stable. When `out_ready`=1 → IDLE.
- Divide by zero: DIVU returns all ones, REMU returns A, `err`=0.
- `zero` is registered with `out` and always equals (`out`==0).
- `in_ready`=0 in MUL, DIV and DONE. Inputs presented then are ignored and must be held by the source.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `out`=0, `zero`=1, `err`=0, counter 0.
- Latency (acceptance edge to first cycle with `out_valid`=1):
  - single-cycle, illegal, divide-by-zero: 1 cycle.
  - MUL/MULHU and DIVU/REMU: WIDTH+1 cycles.
- Throughput: at most one op every 2 cycles. A result accepted in cycle n allows a new op to be accepted in cycle n+1.
- Stall: while `out_ready`=0 in DONE, all outputs hold indefinitely.
- Reset mid-operation: aborts immediately to reset values; partial results are discarded and no `out_valid` pulse is emitted.
- Counter wrap: the counter is cleared on every entry to MUL or DIV, so it never carries over between ops.

## Configuration
- `ALU_ITER_DIV_EN` defined: DIV state and divider datapath are compiled in, as above.
- Not defined: DIVU/REMU behave as illegal ops (1-cycle latency, `out`=0, `zero`=1, `err`=1). The DIV state and divider registers are absent.

## Structure
- Package `alu_iter_pkg` holds:
  - op-code localparams: `OP_ADD` … `OP_REMU`;
  - state enum `alu_state_t`: IDLE, MUL, DIV, DONE;
  - helper `is_single_cycle(op)`.
- One sub-module, `alu_iter_seq`, holds the shared shift-add / restoring-divide iteration datapath (accumulator, counter, step logic). The `ALU_ITER_DIV_EN` guard sits inside it. The top level keeps the FSM, the combinational single-cycle ops and the handshake.

## Test plan
- Reset then idle, WIDTH=32: all outputs at reset values. ADD A=5, B=7 → `out`=12 one cycle later, `zero`=0, `err`=0.
- SLT A=0xFFFFFFFF, B=1 → 1. SLTU with the same operands → 0. SLL A=33, B=1 → 2, since the shift amount is the low 5 bits.
- MUL A=0xFFFFFFFF, B=2 → `out`=0xFFFFFFFE after 33 cycles. MULHU with the same operands → 1. `in_ready`=0 throughout the iteration.
- With DIV enabled:
  - DIVU 100/7 → 14; REMU 100/7 → 2, each after 33 cycles.
  - DIVU x/0 → 0xFFFFFFFF after 1 cycle.
  - Without DIV: DIVU → `err`=1, `out`=0.
- Back-pressure and reset: hold `out_ready`=0 for 10 cycles in DONE → outputs stable and `in_valid` ignored. Assert `rst_n`=0 mid-MUL → `out_valid` never rises, state IDLE.
- Illegal op 1110 → `out`=0, `zero`=1, `err`=1 after 1 cycle. Next legal op clears `err`.
